rle_run_prefetch: RTL and testbench

- Sits between `spi_flash_controller` and the VGA run decoder.
- Drives the flash controller's start/continue/stop handshake to stream 32-bit words from a frame base address.
- Buffers the words in a small FIFO and presents them downstream as 16-bit runs (6-bit colour, 10-bit length) over a valid/ready interface.
- A restart pulse (per frame) flushes the buffered data and re-issues the read from `base_addr`.

---
 rtl/rle_run_prefetch.sv | 127 ++++++++++++
 tb/tb_rle_run_prefetch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_run_prefetch.sv
// Flash word prefetcher: streams 32-bit words into a FIFO, emits 16-bit runs.
// Optional underrun counter port enabled with RLE_PREFETCH_STATS_EN.
module rle_run_prefetch #(
  parameter int ADDR_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic                 frame_restart,
  output logic [ADDR_BITS-1:0] spi_addr,
  output logic                 spi_start_read,
  output logic                 spi_continue_read,
  output logic                 spi_stop_read,
  input  logic [31:0]          spi_data,
  input  logic                 spi_busy,
  output logic                 run_valid,
  input  logic                 run_ready,
  output logic [5:0]           run_colour,
  output logic [9:0]           run_length
`ifdef RLE_PREFETCH_STATS_EN
  ,
  output logic [7:0]           underrun_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_HOLD,
    S_CONT,
    S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          half;
  logic          push, pop, take;
  logic [31:0]   head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    spi_start_read    = 1'b0;
    spi_continue_read = 1'b0;
    spi_stop_read     = 1'b0;
    unique case (state)
      S_IDLE:  spi_stop_read = 1'b1;
      S_ISSUE: spi_start_read = 1'b1;
      S_CONT:  spi_continue_read = 1'b1;
      S_DRAIN: spi_stop_read = 1'b1;
      default: ;
    endcase
    if (frame_restart) begin
      state_nx = (state == S_IDLE) ? S_ISSUE : S_DRAIN;
    end else begin
      unique case (state)
        S_IDLE:  state_nx = S_IDLE;
        S_ISSUE: state_nx = S_BUSY;
        S_BUSY:  if (!spi_busy) state_nx = S_HOLD;
        S_HOLD:  if (count < FULL) state_nx = S_CONT;
        S_CONT:  state_nx = S_BUSY;
        S_DRAIN: if (!spi_busy) state_nx = S_ISSUE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign head       = mem[rptr];
  assign run_valid  = (count != '0);
  assign run_colour = half ? head[15:10] : head[31:26];
  assign run_length = half ? head[9:0]   : head[25:16];

  assign take = run_valid && run_ready;
  assign push = (state == S_BUSY) && !spi_busy && !frame_restart;
  assign pop  = take && half && !frame_restart;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= spi_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      half     <= 1'b0;
      spi_addr <= '0;
    end else if (frame_restart) begin
      // flush wins over any push or pop this edge
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      half     <= 1'b0;
      spi_addr <= base_addr;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (take) half <= ~half;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef RLE_PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underrun_count <= '0;
    else if (frame_restart)
      underrun_count <= '0;
    else if (run_ready && !run_valid && underrun_count != 8'hFF)
      underrun_count <= underrun_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rle_run_prefetch.sv
// Directed bench for rle_run_prefetch with a simple flash controller model.
// Start reads stay busy 56 cycles, continues 32 cycles.
module tb_rle_run_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] base_addr;
  logic        frame_restart;
  logic [15:0] spi_addr;
  logic        spi_start_read;
  logic        spi_continue_read;
  logic        spi_stop_read;
  logic [31:0] spi_data;
  logic        spi_busy;
  logic        run_valid;
  logic        run_ready;
  logic [5:0]  run_colour;
  logic [9:0]  run_length;
`ifdef RLE_PREFETCH_STATS_EN
  logic [7:0]  underrun_count;
`endif

  int total = 0;
  int bad   = 0;

  rle_run_prefetch #(.ADDR_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .base_addr         (base_addr),
    .frame_restart     (frame_restart),
    .spi_addr          (spi_addr),
    .spi_start_read    (spi_start_read),
    .spi_continue_read (spi_continue_read),
    .spi_stop_read     (spi_stop_read),
    .spi_data          (spi_data),
    .spi_busy          (spi_busy),
    .run_valid         (run_valid),
    .run_ready         (run_ready),
    .run_colour        (run_colour),
    .run_length        (run_length)
`ifdef RLE_PREFETCH_STATS_EN
    ,
    .underrun_count    (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    case (a)
      16'h0100: word_at = 32'h1234ABCD;
      16'h0104: word_at = 32'h8001FC00;
      16'h0108: word_at = 32'hFFFFFFFF;
      16'h010C: word_at = 32'h04000800;
      default:  word_at = {a, a};
    endcase
  endfunction

  logic [5:0]  m_cnt;
  logic [15:0] m_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_busy <= 1'b0;
      m_cnt    <= '0;
      m_ptr    <= '0;
      spi_data <= '0;
    end else if (!spi_busy) begin
      if (spi_start_read) begin
        spi_busy <= 1'b1;
        m_cnt    <= 6'd55;
        m_ptr    <= spi_addr;
      end else if (spi_continue_read) begin
        spi_busy <= 1'b1;
        m_cnt    <= 6'd31;
      end
    end else if (m_cnt == 0) begin
      spi_busy <= 1'b0;
      spi_data <= word_at(m_ptr);
      m_ptr    <= m_ptr + 16'd4;
    end else begin
      m_cnt <= m_cnt - 6'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    base_addr = '0;
    frame_restart = 1'b0;
    run_ready = 1'b0;
    step();
    step();
    total++;
    if ({spi_start_read, spi_continue_read, spi_stop_read, run_valid}
        !== 4'b0010) begin
      bad++;
      $display("FAIL reset_hs got=%b exp=0010",
        {spi_start_read, spi_continue_read, spi_stop_read, run_valid});
    end
    total++;
    if (spi_addr !== 16'h0000) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0000", spi_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    int errs;
    base_addr = 16'h0100;
    frame_restart = 1'b1;
    step();
    frame_restart = 1'b0;
    total++;
    if ({spi_start_read, spi_addr} !== {1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL lat_issue got=%b/%h exp=1/0100",
        spi_start_read, spi_addr);
    end
    errs = 0;
    for (int c = 2; c <= 57; c++) begin
      step();
      if (!(spi_busy === 1'b1 && run_valid === 1'b0 &&
            spi_start_read === 1'b0)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL lat_busy got=%0d bad cycles exp=0", errs);
    end
    step();
    total++;
    if ({spi_busy, run_valid} !== 2'b00) begin
      bad++;
      $display("FAIL lat_c58 got=%b exp=00", {spi_busy, run_valid});
    end
    step();
    total++;
    if ({run_valid, run_colour, run_length} !== {1'b1, 6'h04, 10'h234}) begin
      bad++;
      $display("FAIL lat_c59 got=%b/%h/%h exp=1/04/234",
        run_valid, run_colour, run_length);
    end
  endtask

  task automatic test_unpack();
    logic [15:0] exp_runs [4];
    int n;
    int conts;
    exp_runs[0] = {6'h04, 10'h234};
    exp_runs[1] = {6'h2A, 10'h3CD};
    exp_runs[2] = {6'h20, 10'h001};
    exp_runs[3] = {6'h3F, 10'h000};
    n = 0;
    conts = 0;
    run_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (spi_continue_read) conts++;
      if (run_valid) begin
        total++;
        if ({run_colour, run_length} !== exp_runs[n]) begin
          bad++;
          $display("FAIL unpack_run%0d got=%h exp=%h",
            n, {run_colour, run_length}, exp_runs[n]);
        end
        n++;
      end
      if (n == 4) break;
      step();
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL unpack_count got=%0d exp=4", n);
    end
    total++;
    if (conts != 2) begin
      bad++;
      $display("FAIL unpack_conts got=%0d exp=2", conts);
    end
    step();
    run_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int done;
    int conts;
    logic pb;
    done = 0;
    pb = spi_busy;
    for (int c = 0; c < 250; c++) begin
      step();
      if (pb && !spi_busy) done++;
      pb = spi_busy;
    end
    total++;
    if (done != 4) begin
      bad++;
      $display("FAIL bp_fill got=%0d exp=4", done);
    end
    total++;
    if ({spi_start_read, spi_continue_read, spi_stop_read, spi_busy,
         run_valid} !== 5'b00001) begin
      bad++;
      $display("FAIL bp_hold got=%b exp=00001",
        {spi_start_read, spi_continue_read, spi_stop_read, spi_busy,
         run_valid});
    end
    total++;
    if ({run_colour, run_length} !== {6'h3F, 10'h3FF}) begin
      bad++;
      $display("FAIL bp_head got=%h exp=%h",
        {run_colour, run_length}, {6'h3F, 10'h3FF});
    end
    run_ready = 1'b1;
    step();
    step();
    run_ready = 1'b0;
    total++;
    if ({run_valid, run_colour, run_length} !== {1'b1, 6'h01, 10'h000}) begin
      bad++;
      $display("FAIL bp_next got=%b/%h/%h exp=1/01/000",
        run_valid, run_colour, run_length);
    end
    conts = 0;
    done = 0;
    pb = spi_busy;
    for (int c = 0; c < 60; c++) begin
      if (spi_continue_read) conts++;
      step();
      if (pb && !spi_busy) done++;
      pb = spi_busy;
    end
    total++;
    if ({conts, done} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL bp_one_cont got=%0d/%0d exp=1/1", conts, done);
    end
  endtask

  task automatic test_restart_hold();
    int waitc;
    base_addr = 16'h0200;
    frame_restart = 1'b1;
    step();
    frame_restart = 1'b0;
    total++;
    if ({spi_stop_read, run_valid, spi_start_read, spi_addr}
        !== {3'b100, 16'h0200}) begin
      bad++;
      $display("FAIL rh_drain got=%b%b%b/%h exp=100/0200",
        spi_stop_read, run_valid, spi_start_read, spi_addr);
    end
    step();
    total++;
    if ({spi_start_read, spi_stop_read} !== 2'b10) begin
      bad++;
      $display("FAIL rh_issue got=%b exp=10",
        {spi_start_read, spi_stop_read});
    end
    step();
    total++;
    if ({spi_start_read, spi_busy} !== 2'b01) begin
      bad++;
      $display("FAIL rh_busy got=%b exp=01", {spi_start_read, spi_busy});
    end
    waitc = 0;
    while (!run_valid && waitc < 100) begin
      step();
      waitc++;
    end
    total++;
    if (waitc != 57) begin
      bad++;
      $display("FAIL rh_wait got=%0d exp=57", waitc);
    end
    total++;
    if ({run_colour, run_length} !== {6'h00, 10'h200}) begin
      bad++;
      $display("FAIL rh_run got=%h exp=%h",
        {run_colour, run_length}, {6'h00, 10'h200});
    end
  endtask

  task automatic test_restart_busy();
    int errs;
    int waitc;
    for (int c = 0; c < 10; c++) step();
    total++;
    if (spi_busy !== 1'b1) begin
      bad++;
      $display("FAIL rb_mid got=%b exp=1", spi_busy);
    end
    base_addr = 16'h0100;
    frame_restart = 1'b1;
    step();
    frame_restart = 1'b0;
    errs = 0;
    waitc = 0;
    while (spi_busy === 1'b1 && waitc < 64) begin
      if (!(spi_stop_read === 1'b1 && run_valid === 1'b0 &&
            spi_start_read === 1'b0)) errs++;
      step();
      waitc++;
    end
    total++;
    if ({errs, spi_busy} !== {32'd0, 1'b0}) begin
      bad++;
      $display("FAIL rb_drain got=%0d/%b exp=0/0", errs, spi_busy);
    end
    total++;
    if ({spi_start_read, spi_stop_read, run_valid} !== 3'b010) begin
      bad++;
      $display("FAIL rb_lowbusy got=%b exp=010",
        {spi_start_read, spi_stop_read, run_valid});
    end
    step();
    total++;
    if ({spi_start_read, spi_addr} !== {1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL rb_issue got=%b/%h exp=1/0100",
        spi_start_read, spi_addr);
    end
    waitc = 0;
    while (!run_valid && waitc < 100) begin
      step();
      waitc++;
    end
    total++;
    if ({waitc, run_colour, run_length} !== {32'd58, 6'h04, 10'h234}) begin
      bad++;
      $display("FAIL rb_first got=%0d/%h/%h exp=58/04/234",
        waitc, run_colour, run_length);
    end
  endtask

`ifdef RLE_PREFETCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    run_ready = 1'b0;
    frame_restart = 1'b0;
    step();
    rst = 1'b0;
    total++;
    if (underrun_count !== 8'd0) begin
      bad++;
      $display("FAIL st_reset got=%0d exp=0", underrun_count);
    end
    base_addr = 16'h0100;
    frame_restart = 1'b1;
    step();
    frame_restart = 1'b0;
    run_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    run_ready = 1'b0;
    total++;
    if (underrun_count !== 8'd10) begin
      bad++;
      $display("FAIL st_count got=%0d exp=10", underrun_count);
    end
    frame_restart = 1'b1;
    step();
    frame_restart = 1'b0;
    total++;
    if (underrun_count !== 8'd0) begin
      bad++;
      $display("FAIL st_clear got=%0d exp=0", underrun_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_unpack();
    test_backpressure();
    test_restart_hold();
    test_restart_busy();
`ifdef RLE_PREFETCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
